// File: rtl/apb3_decoder_wd.sv
// apb3_decoder_wd: fans one APB3 master out to equal-size slave regions. Unmapped
// addresses get a decode error, and a watchdog aborts stalled transfers with PSLVERR.
module apb3_decoder_wd #(
   parameter int unsigned APB_ADDR_WIDTH_P   = 32,
   parameter int unsigned APB_DATA_WIDTH_P   = 32,
   parameter int unsigned APB_NR_OF_SLAVES_P = 4,
   parameter int unsigned APB_SLAVE_SPAN_P   = 12,
   parameter logic [63:0] APB_BASE_ADDR_P    = 64'h0,
   parameter int unsigned APB_TIMEOUT_P      = 16
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [APB_ADDR_WIDTH_P-1:0]                  apb_paddr_i,
   input  logic                                         apb_psel_i,
   input  logic                                         apb_penable_i,
   input  logic                                         apb_pwrite_i,
   input  logic [APB_DATA_WIDTH_P-1:0]                  apb_pwdata_i,
   output logic [APB_DATA_WIDTH_P-1:0]                  apb_prdata_o,
   output logic                                         apb_pready_o,
   output logic                                         apb_pslverr_o,
   output logic [APB_ADDR_WIDTH_P-1:0]                  slv_paddr_o,
   output logic                                         slv_pwrite_o,
   output logic [APB_DATA_WIDTH_P-1:0]                  slv_pwdata_o,
   output logic                                         slv_penable_o,
   output logic [APB_NR_OF_SLAVES_P-1:0]                slv_psel_o,
   input  logic [APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P-1:0] slv_prdata_i,
   input  logic [APB_NR_OF_SLAVES_P-1:0]                slv_pready_i,
   input  logic [APB_NR_OF_SLAVES_P-1:0]                slv_pslverr_i,
   output logic                                         decerr_o,
   output logic                                         timeout_o
);

   localparam int unsigned AW    = APB_ADDR_WIDTH_P;
   localparam int unsigned DW    = APB_DATA_WIDTH_P;
   localparam int unsigned NS    = APB_NR_OF_SLAVES_P;
   localparam int unsigned IDX_W = (NS > 1) ? $clog2(NS) : 1;
   localparam int unsigned CNT_W = (APB_TIMEOUT_P > 0) ? $clog2(APB_TIMEOUT_P + 1) : 1;

   localparam logic [AW-1:0]    BASE      = APB_BASE_ADDR_P[AW-1:0];
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(APB_TIMEOUT_P);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ABORT
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               mapped_q, mapped_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [AW-1:0]      addr_off;
   logic [AW-1:0]      idx_full;
   logic               addr_mapped;
   logic [NS-1:0]      dec_onehot;
   logic [NS-1:0]      sel_onehot;
   logic [DW-1:0]      sel_prdata;
   logic               sel_pready;
   logic               sel_pslverr;
   logic [CNT_W-1:0]   cnt_inc;

   assign slv_paddr_o  = apb_paddr_i;
   assign slv_pwrite_o = apb_pwrite_i;
   assign slv_pwdata_o = apb_pwdata_i;

   assign addr_off    = apb_paddr_i - BASE;
   assign idx_full    = addr_off >> APB_SLAVE_SPAN_P;
   assign addr_mapped = (apb_paddr_i >= BASE) && (idx_full < AW'(NS));
   assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // Live decode for the setup phase, and the mux of the slave latched for the access phase
   always_comb begin
      dec_onehot  = '0;
      sel_onehot  = '0;
      sel_prdata  = '0;
      sel_pready  = 1'b0;
      sel_pslverr = 1'b0;
      for (int k = 0; k < int'(NS); k++) begin
         dec_onehot[k] = addr_mapped && (idx_full == AW'(k));
         if (idx_q == IDX_W'(k)) begin
            sel_onehot[k] = 1'b1;
            sel_prdata    = slv_prdata_i[k*DW +: DW];
            sel_pready    = slv_pready_i[k];
            sel_pslverr   = slv_pslverr_i[k];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      mapped_d      = mapped_q;
      cnt_d         = cnt_q;
      slv_psel_o    = '0;
      slv_penable_o = 1'b0;
      apb_prdata_o  = '0;
      apb_pready_o  = 1'b0;
      apb_pslverr_o = 1'b0;
      decerr_o      = 1'b0;
      timeout_o     = 1'b0;

      case (state_q)
         IDLE: begin
            slv_psel_o = apb_psel_i ? dec_onehot : '0;
            if (apb_psel_i && !apb_penable_i) begin
               idx_d    = idx_full[IDX_W-1:0];
               mapped_d = addr_mapped;
               cnt_d    = '0;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (!apb_psel_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (mapped_q) begin
               slv_psel_o    = sel_onehot;
               slv_penable_o = apb_penable_i;
               apb_prdata_o  = sel_prdata;
               apb_pready_o  = sel_pready;
               apb_pslverr_o = sel_pslverr;
               if (sel_pready) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
                  // The counter saturates, so a disabled watchdog just holds it at its maximum
                  if ((APB_TIMEOUT_P != 0) && (cnt_inc >= CNT_LIMIT)) begin
                     state_d = ABORT;
                  end
               end
            end else begin
               apb_pready_o  = 1'b1;
               apb_pslverr_o = 1'b1;
               decerr_o      = 1'b1;
               state_d       = IDLE;
            end
         end
         ABORT: begin
            if (apb_psel_i) begin
               apb_pready_o  = 1'b1;
               apb_pslverr_o = 1'b1;
               timeout_o     = 1'b1;
            end
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs go quiet as soon as reset asserts, even while the master still holds PSEL
      if (!rst_n) begin
         slv_psel_o    = '0;
         slv_penable_o = 1'b0;
         apb_prdata_o  = '0;
         apb_pready_o  = 1'b0;
         apb_pslverr_o = 1'b0;
         decerr_o      = 1'b0;
         timeout_o     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         mapped_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         mapped_q <= mapped_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_apb3_decoder_wd.sv
// tb_apb3_decoder_wd: scenario tasks plus randomized transfers, each checked cycle by cycle
// against a reference that derives slave, completion cycle and response from address arithmetic.
`timescale 1ns/1ps
module tb_apb3_decoder_wd;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int NS   = 4;
   localparam int SPAN = 12;
   localparam int TMO  = 16;
   localparam longint unsigned BASE = 0;

   logic              clk;
   logic              rst_n;
   logic [AW-1:0]     paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [DW-1:0]     pwdata;
   logic [DW-1:0]     apb_prdata_o;
   logic              apb_pready_o;
   logic              apb_pslverr_o;
   logic [AW-1:0]     slv_paddr_o;
   logic              slv_pwrite_o;
   logic [DW-1:0]     slv_pwdata_o;
   logic              slv_penable_o;
   logic [NS-1:0]     slv_psel_o;
   logic [NS*DW-1:0]  slv_prdata;
   logic [NS-1:0]     slv_pready;
   logic [NS-1:0]     slv_pslverr;
   logic              decerr_o;
   logic              timeout_o;

   int check_cnt;
   int pass_cnt;

   logic [40:0] obs;
   assign obs = {slv_psel_o, slv_penable_o, apb_pready_o, apb_pslverr_o,
                 apb_prdata_o, decerr_o, timeout_o};

   apb3_decoder_wd #(
      .APB_ADDR_WIDTH_P  (AW),
      .APB_DATA_WIDTH_P  (DW),
      .APB_NR_OF_SLAVES_P(NS),
      .APB_SLAVE_SPAN_P  (SPAN),
      .APB_BASE_ADDR_P   (64'h0),
      .APB_TIMEOUT_P     (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .apb_paddr_i  (paddr),
      .apb_psel_i   (psel),
      .apb_penable_i(penable),
      .apb_pwrite_i (pwrite),
      .apb_pwdata_i (pwdata),
      .apb_prdata_o (apb_prdata_o),
      .apb_pready_o (apb_pready_o),
      .apb_pslverr_o(apb_pslverr_o),
      .slv_paddr_o  (slv_paddr_o),
      .slv_pwrite_o (slv_pwrite_o),
      .slv_pwdata_o (slv_pwdata_o),
      .slv_penable_o(slv_penable_o),
      .slv_psel_o   (slv_psel_o),
      .slv_prdata_i (slv_prdata),
      .slv_pready_i (slv_pready),
      .slv_pslverr_i(slv_pslverr),
      .decerr_o     (decerr_o),
      .timeout_o    (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL sim_time_limit: run did not finish within bound");
      $fatal(1, "[TB] time limit expired");
   end

   // Non-target slaves chatter randomly so the bench sees whether the DUT listens to the wrong one
   task automatic drive_noise(input int target);
      for (int k = 0; k < NS; k++) begin
         if (k != target) begin
            slv_prdata[k*DW +: DW] = $urandom;
            slv_pready[k]          = 1'($urandom_range(0, 1));
            slv_pslverr[k]         = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic drive_idle();
      @(negedge clk);
      psel       = 1'b0;
      penable    = 1'b0;
      slv_pready = '0;
      slv_pslverr = '0;
   endtask

   // One full transfer; expectations come from region arithmetic and the wait/timeout rule
   task automatic apply_transfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int waits, input bit err,
                                 input string name);
      longint unsigned a;
      longint unsigned off;
      int              exp_idx;
      int              last;
      int              target;
      bit              mapped;
      bit              abort;
      bit              fwd;
      logic [NS-1:0]   exp_sel;
      logic [40:0]     exp;
      a       = addr;
      off     = a - BASE;
      exp_idx = int'(off / (64'd1 << SPAN));
      mapped  = (a >= BASE) && (off / (64'd1 << SPAN) < NS);
      abort   = 1'b0;
      if (!mapped) last = 1;
      else if (waits < TMO) last = waits + 1;
      else begin
         last  = TMO + 1;
         abort = 1'b1;
      end
      exp_sel = mapped ? (NS'(1) << exp_idx) : '0;
      target  = mapped ? exp_idx : -1;

      @(negedge clk);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = addr;
      pwrite  = wr;
      pwdata  = wdata;
      drive_noise(target);
      if (mapped) begin
         slv_prdata[exp_idx*DW +: DW] = rdata;
         slv_pready[exp_idx]          = 1'b0;
         slv_pslverr[exp_idx]         = 1'b0;
      end
      #1;
      exp = {exp_sel, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      check_cnt++;
      if (obs !== exp) $display("[TB] FAIL %s setup: got %h want %h", name, obs, exp);
      else pass_cnt++;
      check_cnt++;
      if ({slv_paddr_o, slv_pwrite_o, slv_pwdata_o} !== {addr, wr, wdata})
         $display("[TB] FAIL %s passthrough: got %h want %h", name,
                  {slv_paddr_o, slv_pwrite_o, slv_pwdata_o}, {addr, wr, wdata});
      else pass_cnt++;

      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         penable = 1'b1;
         drive_noise(target);
         if (mapped) begin
            slv_prdata[exp_idx*DW +: DW] = rdata;
            slv_pready[exp_idx]          = (n > waits);
            slv_pslverr[exp_idx]         = (n > waits) && err;
         end
         #1;
         fwd = mapped && !(abort && n == last);
         exp = {fwd ? exp_sel : NS'(0), fwd, (n == last),
                (n == last) && (!mapped || abort || err),
                fwd ? rdata : 32'h0, !mapped && (n == last), abort && (n == last)};
         check_cnt++;
         if (obs !== exp) $display("[TB] FAIL %s access%0d: got %h want %h", name, n, obs, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      psel        = 1'b1;
      penable     = 1'b0;
      paddr       = 32'h2000;
      pwrite      = 1'b0;
      pwdata      = '0;
      slv_prdata  = '0;
      slv_pready  = '0;
      slv_pslverr = '0;
      #1;
      check_cnt++;
      if (obs !== 41'h0) $display("[TB] FAIL reset_outputs: got %h want %h", obs, 41'h0);
      else pass_cnt++;
      @(negedge clk);
      psel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_cnt++;
      if (obs !== 41'h0) $display("[TB] FAIL reset_release_idle: got %h want %h", obs, 41'h0);
      else pass_cnt++;
   endtask

   task automatic test_mapped_write();
      apply_transfer(32'h2010, 1'b1, 32'hDEADBEEF, $urandom, 3, 1'b0, "write_0x2010");
      drive_idle();
      #1;
      check_cnt++;
      if (obs !== 41'h0) $display("[TB] FAIL write_0x2010 idle: got %h want %h", obs, 41'h0);
      else pass_cnt++;
   endtask

   task automatic test_decode_error();
      apply_transfer(32'h4000, 1'b0, 32'h0, $urandom, 0, 1'b0, "read_unmapped");
      drive_idle();
      #1;
      check_cnt++;
      if (obs !== 41'h0) $display("[TB] FAIL read_unmapped idle: got %h want %h", obs, 41'h0);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      apply_transfer(32'h1000, 1'b0, 32'h0, $urandom, 1000, 1'b0, "timeout_0x1000");
      drive_idle();
      #1;
      check_cnt++;
      if (obs !== 41'h0) $display("[TB] FAIL timeout_0x1000 idle: got %h want %h", obs, 41'h0);
      else pass_cnt++;
   endtask

   task automatic test_slave_error();
      apply_transfer(32'h3004, 1'b0, 32'h0, 32'h12345678, 0, 1'b1, "slverr_0x3004");
      drive_idle();
   endtask

   task automatic test_back_to_back();
      apply_transfer(32'h0040, 1'b1, $urandom, $urandom, 0, 1'b0, "b2b_write_s0");
      apply_transfer(32'h1010, 1'b0, 32'h0, $urandom, 0, 1'b0, "b2b_read_s1");
      apply_transfer(32'h3FFC, 1'b0, 32'h0, $urandom, 2, 1'b0, "b2b_read_s3_top");
      drive_idle();
   endtask

   // Master walks away mid-transfer; the next transfer must get a full, fresh watchdog budget
   task automatic test_master_abort();
      @(negedge clk);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = 32'h2000;
      pwrite  = 1'b0;
      slv_pready = '0;
      slv_pslverr = '0;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         penable = 1'b1;
      end
      @(negedge clk);
      psel    = 1'b0;
      penable = 1'b0;
      #1;
      check_cnt++;
      if (obs !== 41'h0) $display("[TB] FAIL master_abort: got %h want %h", obs, 41'h0);
      else pass_cnt++;
      apply_transfer(32'h2008, 1'b1, $urandom, $urandom, 15, 1'b0, "after_master_abort");
      drive_idle();
   endtask

   task automatic test_reset_mid_transfer();
      @(negedge clk);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = 32'h1000;
      pwrite  = 1'b0;
      slv_pready = '0;
      slv_pslverr = '0;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         penable = 1'b1;
         #1;
         if (n == 5) begin
            rst_n = 1'b0;
            #1;
            check_cnt++;
            if (obs !== 41'h0) $display("[TB] FAIL reset_mid_transfer: got %h want %h", obs, 41'h0);
            else pass_cnt++;
         end
      end
      @(negedge clk);
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      apply_transfer(32'h0000, 1'b0, 32'h0, $urandom, 15, 1'b0, "after_reset_read");
      drive_idle();
   endtask

   task automatic test_random();
      logic [31:0] addr;
      int          region;
      int          waits;
      for (int i = 0; i < 24; i++) begin
         region = $urandom_range(0, NS);
         if (region == NS) begin
            addr = $urandom;
            if (addr < 32'h4000) addr = addr + 32'h4000;
         end else begin
            addr = 32'(region * 4096 + $urandom_range(0, 4095));
         end
         if ($urandom_range(0, 3) == 0) waits = $urandom_range(14, 20);
         else waits = $urandom_range(0, 5);
         apply_transfer(addr, 1'($urandom_range(0, 1)), $urandom, $urandom, waits,
                        1'($urandom_range(0, 1)), "random");
         if ($urandom_range(0, 1) == 1) drive_idle();
      end
      drive_idle();
   endtask

   initial begin
      check_cnt = 0;
      pass_cnt  = 0;
      test_reset();
      test_mapped_write();
      test_decode_error();
      test_timeout();
      test_slave_error();
      test_back_to_back();
      test_master_abort();
      test_reset_mid_transfer();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/apb3_decoder_wd.md
Name: apb3_decoder_wd

Overview:
- Parametrised APB3 interconnect: one APB3 master port fans out to APB_NR_OF_SLAVES_P slave ports.
- Decodes the address into equal-size slave regions and returns a decode error for unmapped addresses.
- A watchdog aborts stalled transfers with PSLVERR.
- Sits between a bus master (CPU bridge, UART-to-APB) and the register banks of the design's IP blocks.

Parameters:
- APB_ADDR_WIDTH_P, 32, address width.
- APB_DATA_WIDTH_P, 32, data width.
- APB_NR_OF_SLAVES_P, 4, number of slave ports (1..16).
- APB_SLAVE_SPAN_P, 12, log2 of bytes per slave region.
- APB_BASE_ADDR_P, 0, start address of slave 0's region.
- APB_TIMEOUT_P, 16, maximum access cycles without PREADY; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- apb_paddr_i  in  APB_ADDR_WIDTH_P  master address
- apb_psel_i  in  1  master select
- apb_penable_i  in  1  master enable
- apb_pwrite_i  in  1  master write
- apb_pwdata_i  in  APB_DATA_WIDTH_P  master write data
- apb_prdata_o  out  APB_DATA_WIDTH_P  read data to master
- apb_pready_o  out  1  ready to master
- apb_pslverr_o  out  1  error to master
- slv_paddr_o  out  APB_ADDR_WIDTH_P  broadcast address
- slv_pwrite_o  out  1  broadcast write
- slv_pwdata_o  out  APB_DATA_WIDTH_P  broadcast write data
- slv_penable_o  out  1  broadcast enable
- slv_psel_o  out  APB_NR_OF_SLAVES_P  one-hot slave select
- slv_prdata_i  in  APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P  packed read data, slave k at [k*DW +: DW]
- slv_pready_i  in  APB_NR_OF_SLAVES_P  slave ready
- slv_pslverr_i  in  APB_NR_OF_SLAVES_P  slave error
- decerr_o  out  1  one-cycle pulse on decode error
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; wait counter 0; latched index 0.
  - apb_pready_o, apb_pslverr_o, apb_prdata_o, slv_psel_o, slv_penable_o, decerr_o and timeout_o are all 0.
- Decode:
  - off = paddr - APB_BASE_ADDR_P; idx = off >> APB_SLAVE_SPAN_P.
  - Mapped iff paddr >= APB_BASE_ADDR_P and idx < APB_NR_OF_SLAVES_P.
- Broadcast outputs: paddr, pwrite and pwdata pass straight through combinationally.
- FSM states: IDLE, ACCESS, ABORT.
- IDLE:
  - slv_psel_o = mapped ? (psel_i << idx) : 0, combinational, so the setup phase reaches the slave in the same cycle; slv_penable_o = 0.
  - On psel_i=1 and penable_i=0: latch idx and the mapped flag, clear the counter, go to ACCESS.
  - penable_i=1 seen while in IDLE is a master protocol error and is ignored.
- ACCESS, mapped:
  - slv_psel_o = one-hot of the latched idx; slv_penable_o = penable_i.
  - apb_prdata_o, apb_pready_o and apb_pslverr_o are muxed from the latched slave.
  - On slv_pready_i[idx]=1: return to IDLE.
  - Otherwise increment the counter; when the counter reaches APB_TIMEOUT_P (and APB_TIMEOUT_P != 0), go to ABORT.
- ACCESS, unmapped:
  - slv_psel_o = 0.
  - In the first access cycle: apb_pready_o=1, apb_pslverr_o=1, apb_prdata_o=0, decerr_o=1. Then go to IDLE.
- ABORT (one cycle):
  - slv_psel_o=0, slv_penable_o=0.
  - apb_pready_o=1, apb_pslverr_o=1, apb_prdata_o=0, timeout_o=1.
  - Then go to IDLE.
- Master deasserts psel_i while in ACCESS or ABORT: immediately drive slv_psel_o=0 and apb_pready_o=0, go to IDLE, clear the counter. No pulses are generated.
- Back-to-back transfers: completion goes to IDLE, so a new setup in the following cycle is decoded normally. There is no added idle cycle beyond the APB3 protocol's own setup phase.
- apb_pready_o, apb_pslverr_o and apb_prdata_o are 0 whenever they are not in a completion or forwarded cycle.
- Latency: zero added cycles on the mapped path; a watchdog abort completes on access cycle APB_TIMEOUT_P+1.
- Reset asserted mid-transfer: all outputs go to 0 immediately (async); the slave transfer is dropped without completion.
- Counter width: $clog2(APB_TIMEOUT_P+1); it saturates and never wraps.

Test Plan:
- Write 0xDEADBEEF to 0x2010 (N=4, span 12, base 0); slave 2 raises pready after 3 wait cycles -> slv_psel_o=4'b0100 for the setup cycle plus 4 access cycles; apb_pready_o high for 1 cycle in the 4th access cycle; pslverr 0; other slave selects 0.
- Read 0x4000 (unmapped) -> slv_psel_o=0 throughout; first access cycle apb_pready_o=1, apb_pslverr_o=1, apb_prdata_o=0; decerr_o pulses once.
- Read 0x1000; slave 1 never ready; APB_TIMEOUT_P=16 -> 16 access cycles with apb_pready_o=0; then 1 ABORT cycle with pready=1, pslverr=1, slv_psel_o=0, timeout_o=1; next cycle IDLE.
- Read 0x3004; slave 3 returns prdata 0x12345678 with pslverr=1 and zero wait -> master sees prdata 0x12345678, pslverr=1, pready=1 in the first access cycle; decerr_o=0, timeout_o=0.
- Back-to-back: write to slave 0 completes, then a read from slave 1 has its setup in the next cycle -> slv_psel_o goes 4'b0001 then 4'b0010 with no gap; both complete without error.
- Assert rst_n=0 during the 5th access cycle of a stalled transfer -> all outputs 0 in the same cycle; after release, a read to 0x0000 completes normally with counter restarted from 0.
